ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_if.sv | 29 ++
 rtl/ram_ctrl.sv | 89 ++++++++
 tb/tb_ram_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_if.sv
// Host request/response, fill control and RAM-side signals of ram_ctrl.
// The controller takes the slave modport; the host/RAM environment takes master.
interface ram_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       fill_start;
  logic [3:0] fill_data;
  logic       fill_done;
  logic       ram_csn;
  logic       ram_rwn;
  logic [3:0] ram_addr;
  logic [3:0] ram_data_in;
  logic [3:0] ram_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, fill_start, fill_data, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, fill_done, ram_csn, ram_rwn, ram_addr, ram_data_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, fill_start, fill_data, ram_data_out,
    input  req_ready, rsp_valid, rsp_rdata, fill_done, ram_csn, ram_rwn, ram_addr, ram_data_in
  );
endinterface

// File: rtl/ram_ctrl.sv
// Single-access RAM controller with a 16-location pattern fill.
// RAM-side outputs decode from state and latched registers only.
module ram_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  ram_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WR, RD, FILL} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] addr_q;
  logic [3:0] wdata_q;
  logic [3:0] fill_q;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = 1'b0;
    bus.ram_csn     = 1'b1;
    bus.ram_rwn     = 1'b1;
    bus.ram_addr    = '0;
    bus.ram_data_in = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        // A fill wins over a simultaneous request; the request stays pending on the host side.
        if (bus.fill_start)     state_nxt = FILL;
        else if (bus.req_valid) state_nxt = bus.req_we ? WR : RD;
      end
      WR: begin
        bus.ram_csn     = 1'b0;
        bus.ram_rwn     = 1'b0;
        bus.ram_addr    = addr_q;
        bus.ram_data_in = wdata_q;
        state_nxt       = IDLE;
      end
      RD: begin
        bus.ram_csn  = 1'b0;
        bus.ram_addr = addr_q;
        state_nxt    = IDLE;
      end
      FILL: begin
        bus.ram_csn     = 1'b0;
        bus.ram_rwn     = 1'b0;
        bus.ram_addr    = cnt;
        bus.ram_data_in = fill_q;
        if (cnt == 4'hF) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      fill_q        <= '0;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.fill_done <= 1'b0;
    end else begin
      bus.rsp_valid <= (state == WR) || (state == RD);
      bus.fill_done <= (state == FILL) && (cnt == 4'hF);
      case (state)
        IDLE: begin
          if (bus.fill_start) begin
            fill_q <= bus.fill_data;
            cnt    <= '0;
          end else if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        WR:   bus.rsp_rdata <= '0;
        RD:   bus.rsp_rdata <= bus.ram_data_out;
        // Counter parks at 15 so it can never carry the FSM back into another pass.
        FILL: if (cnt != 4'hF) cnt <= cnt + 4'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl with a behavioural 16x4 RAM attached to the RAM port.
module tb_ram_ctrl;
  logic clk;
  logic rst_n;
  ram_ctrl_if bus ();

  ram_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] mem [16];
  assign bus.ram_data_out = bus.ram_csn ? 4'h0 : mem[bus.ram_addr];
  always @(posedge clk) if (!bus.ram_csn && !bus.ram_rwn) mem[bus.ram_addr] <= bus.ram_data_in;

  int         checks = 0;
  int         failures = 0;
  int         fill_cnt = 0;
  int         exp_fill = 0;
  logic [3:0] exp_mem [16];
  logic [3:0] sb_q [$];
  logic       b2b = 1'b0;
  logic       have_prev = 1'b0;
  time        last_t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fill_done) fill_cnt++;
    if (bus.rsp_valid && bus.fill_done) check("rsp_fill_overlap", 1, 0);
    if (bus.rsp_valid) begin
      if (sb_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_rdata", 32'(bus.rsp_rdata), 32'(sb_q.pop_front()));
      if (b2b && have_prev) check("rsp_rate", 32'($time - last_t), 32'd20);
      have_prev = b2b;
      last_t = $time;
    end
    if (!b2b) have_prev = 1'b0;
  end

  task automatic do_req(input logic we, input logic [3:0] a, input logic [3:0] d);
    int unsigned n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("req_wait_timeout", 0, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (we) begin
      exp_mem[a] = d;
      sb_q.push_back(4'h0);
    end else begin
      sb_q.push_back(exp_mem[a]);
    end
  endtask

  task automatic do_fill(input logic [3:0] d);
    int unsigned n;
    @(negedge clk);
    bus.fill_start = 1'b1;
    bus.fill_data  = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("fill_wait_timeout", 0, 1);
    @(posedge clk);
    #1 bus.fill_start = 1'b0;
    exp_fill++;
    for (int i = 0; i < 16; i++) begin
      check("fill_csn", 32'(bus.ram_csn), 0);
      check("fill_rwn", 32'(bus.ram_rwn), 0);
      check("fill_addr", 32'(bus.ram_addr), 32'(i));
      check("fill_din", 32'(bus.ram_data_in), 32'(d));
      check("fill_ready", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1;
    end
    check("fill_done_pulse", 32'(bus.fill_done), 1);
    check("fill_end_csn", 32'(bus.ram_csn), 1);
    for (int i = 0; i < 16; i++) exp_mem[i] = d;
  endtask

  task automatic read_all();
    b2b = 1'b1;
    for (int a = 0; a < 16; a++) do_req(1'b0, 4'(a), 4'h0);
    repeat (3) @(posedge clk);
    b2b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'h0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 4'h0;
    bus.req_wdata  = 4'h0;
    bus.fill_start = 1'b0;
    bus.fill_data  = 4'h0;
    #3;
    check("rst_csn", 32'(bus.ram_csn), 1);
    check("rst_rwn", 32'(bus.ram_rwn), 1);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_din", 32'(bus.ram_data_in), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_fill_done", 32'(bus.fill_done), 0);
    repeat (2) @(posedge clk);

    // Write presented with reset release: accepted on the first active edge.
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_rst", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'hA; bus.req_wdata = 4'h3;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    exp_mem[4'hA] = 4'h3;
    sb_q.push_back(4'h0);
    check("wr_csn", 32'(bus.ram_csn), 0);
    check("wr_rwn", 32'(bus.ram_rwn), 0);
    check("wr_addr", 32'(bus.ram_addr), 32'hA);
    check("wr_din", 32'(bus.ram_data_in), 32'h3);
    check("wr_ready", 32'(bus.req_ready), 0);
    check("wr_rsp_early", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    check("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    check("wr_cmd_end", 32'(bus.ram_csn), 1);
    @(posedge clk); #1;
    check("wr_rsp_one", 32'(bus.rsp_valid), 0);

    do_req(1'b0, 4'hA, 4'h0);
    check("rd_csn", 32'(bus.ram_csn), 0);
    check("rd_rwn", 32'(bus.ram_rwn), 1);
    check("rd_addr", 32'(bus.ram_addr), 32'hA);
    check("rd_din", 32'(bus.ram_data_in), 0);
    repeat (3) @(posedge clk);

    // Reset in RD abandons the read with no response.
    do_req(1'b0, 4'hA, 4'h0);
    rst_n = 1'b0;
    #1;
    check("rst_rd_csn", 32'(bus.ram_csn), 1);
    void'(sb_q.pop_back());
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    do_fill(4'h5);
    read_all();

    // Fill and request together: fill taken, held request served after fill_done.
    @(negedge clk);
    bus.fill_start = 1'b1; bus.fill_data = 4'hC;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'h3;
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'hC;
    sb_q.push_back(4'hC);
    @(posedge clk);
    #1 bus.fill_start = 1'b0;
    exp_fill++;
    check("col_fill_csn", 32'(bus.ram_csn), 0);
    check("col_fill_rwn", 32'(bus.ram_rwn), 0);
    check("col_fill_addr", 32'(bus.ram_addr), 0);
    n = 0;
    while (!bus.fill_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("col_fill_len", n, 16);
    @(negedge clk);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("col_rd_csn", 32'(bus.ram_csn), 0);
    check("col_rd_rwn", 32'(bus.ram_rwn), 1);
    check("col_rd_addr", 32'(bus.ram_addr), 32'h3);
    repeat (3) @(posedge clk);

    for (int a = 0; a < 16; a++) do_req(1'b1, 4'(a), 4'(a + 1));
    repeat (2) @(posedge clk);
    read_all();

    // Reset with the fill counter at 7 leaves 7..F untouched.
    @(negedge clk);
    bus.fill_start = 1'b1; bus.fill_data = 4'h5;
    @(posedge clk);
    #1 bus.fill_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_addr", 32'(bus.ram_addr), 7);
    rst_n = 1'b0;
    #1;
    check("fill_rst_csn", 32'(bus.ram_csn), 1);
    check("fill_rst_done", 32'(bus.fill_done), 0);
    for (int i = 0; i < 7; i++) exp_mem[i] = 4'h5;
    @(negedge clk) rst_n = 1'b1;
    check("fill_rst_ready", 32'(bus.req_ready), 1);
    read_all();

    // Request pulsed during RD is ignored.
    do_req(1'b0, 4'h2, 4'h0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'h2; bus.req_wdata = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.req_we = 1'b0;
    check("ign_csn", 32'(bus.ram_csn), 1);
    check("ign_rsp", 32'(bus.rsp_valid), 1);
    repeat (3) @(posedge clk);
    do_req(1'b0, 4'h2, 4'h0);
    repeat (4) @(posedge clk);

    check("sb_empty", 32'(sb_q.size()), 0);
    check("fill_done_count", 32'(fill_cnt), 32'(exp_fill));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
